// File: rtl/wrr_pkg.sv
// Shared types and defaults for the weighted round-robin arbiter.
package wrr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wrr_state_e;

    localparam int WRR_N_DEF  = 4;
    localparam int WRR_WW_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of (req & mask) at or after pointer,
// wrapping from N-1 back to 0.
module rr_pick
    import wrr_pkg::*;
#(
    parameter int N  = WRR_N_DEF,
    parameter int IW = $clog2(WRR_N_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index
);

    logic [N-1:0]  w_mreq;
    logic [IW-1:0] w_idx;
    logic          w_found;

    assign w_mreq = req & mask;

    always_comb begin
        onehot  = '0;
        index   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IW'((int'(pointer) + k) % N);
            if (!w_found && w_mreq[w_idx]) begin
                w_found       = 1'b1;
                onehot[w_idx] = 1'b1;
                index         = w_idx;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-grant beat credit.
// Optional per-requester grant counters are enabled by defining WRR_GRANT_CNT_EN.
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int N  = WRR_N_DEF,
    parameter int WW = WRR_WW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WW-1:0]      weight,
    input  logic                 ack,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
`ifdef WRR_GRANT_CNT_EN
    ,
    output logic [N*16-1:0]      grant_cnt
`endif
);

    localparam int IW = $clog2(N);

    wrr_state_e    r_state, w_nxt_state;
    logic [IW-1:0] r_ptr, w_nxt_ptr;
    logic [IW-1:0] r_grant_id, w_nxt_id;
    logic [IW-1:0] w_ptr_inc, w_pick_ptr, w_pick_idx, w_load_id;
    logic [WW-1:0] r_credit, w_nxt_credit, w_load_wt;
    logic [N-1:0]  r_grant, w_nxt_grant, w_pick_oh;
    logic          w_release, w_load;

    assign w_release  = (r_state == BUSY) &&
                        ((ack && (r_credit == WW'(1))) || !req[r_grant_id]);
    assign w_ptr_inc  = (r_grant_id == IW'(N - 1)) ? '0 : r_grant_id + IW'(1);
    // On release, arbitration already starts from the post-release pointer.
    assign w_pick_ptr = (r_state == BUSY) ? w_ptr_inc : r_ptr;

    // Masking the current grantee lets others win first; it is re-granted only if alone.
    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (req),
        .mask    (~r_grant),
        .pointer (w_pick_ptr),
        .onehot  (w_pick_oh),
        .index   (w_pick_idx)
    );

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_ptr    = r_ptr;
        w_nxt_credit = r_credit;
        w_nxt_grant  = r_grant;
        w_nxt_id     = r_grant_id;
        w_load       = 1'b0;
        w_load_id    = w_pick_idx;
        case (r_state)
            IDLE: begin
                if (|req) w_load = 1'b1;
            end
            BUSY: begin
                if (w_release) begin
                    w_nxt_ptr = w_ptr_inc;
                    if (|w_pick_oh) begin
                        w_load = 1'b1;
                    end else if (req[r_grant_id]) begin
                        w_load    = 1'b1;
                        w_load_id = r_grant_id;
                    end else begin
                        w_nxt_state  = IDLE;
                        w_nxt_grant  = '0;
                        w_nxt_id     = '0;
                        w_nxt_credit = '0;
                    end
                end else if (ack) begin
                    w_nxt_credit = r_credit - WW'(1);
                end
            end
        endcase
        w_load_wt = weight[w_load_id*WW +: WW];
        if (w_load) begin
            w_nxt_state            = BUSY;
            w_nxt_grant            = '0;
            w_nxt_grant[w_load_id] = 1'b1;
            w_nxt_id               = w_load_id;
            w_nxt_credit           = (w_load_wt == '0) ? WW'(1) : w_load_wt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_credit   <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_ptr      <= w_nxt_ptr;
            r_credit   <= w_nxt_credit;
            r_grant    <= w_nxt_grant;
            r_grant_id <= w_nxt_id;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = r_grant_id;

`ifdef WRR_GRANT_CNT_EN
    logic [N-1:0][15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_load && (w_load_id == IW'(i)) && (r_cnt[i] != 16'hFFFF))
                    r_cnt[i] <= r_cnt[i] + 16'd1;
            end
        end
    end

    assign grant_cnt = r_cnt;
`endif

endmodule
